// File: rtl/relu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relu_arbiter_pkg
//  Description : Shared field widths, FSM state encoding and operand/result
//                record types for the RELU arbiter and its picker.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Contents
//    EXP_IN_W / MAN_IN_W / FLT_IN_W : operand field widths (1+6+12 = 19)
//    EXP_OUT_W / MAN_OUT_W          : result field widths  (1+5+6  = 12)
//    CNT_W                          : latency counter width (0..7 cycles)
//    S_IDLE / S_WAIT / S_RESULT     : FSM state encoding
//    operand_t / result_t           : packed float records
// ============================================================================
package relu_arbiter_pkg;

  localparam int EXP_IN_W  = 6;
  localparam int MAN_IN_W  = 12;
  localparam int EXP_OUT_W = 5;
  localparam int MAN_OUT_W = 6;
  localparam int FLT_IN_W  = 1 + EXP_IN_W + MAN_IN_W;

  // Wide enough for the largest supported RELU latency (7).
  localparam int CNT_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_WAIT   = 2'd1;
  localparam state_t S_RESULT = 2'd2;

  typedef struct packed {
    logic                sign;
    logic [EXP_IN_W-1:0] exponent;
    logic [MAN_IN_W-1:0] mantissa;
  } operand_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_OUT_W-1:0] exponent;
    logic [MAN_OUT_W-1:0] mantissa;
  } result_t;

endpackage : relu_arbiter_pkg
`default_nettype wire

// File: rtl/relu_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : relu_arbiter_rr_picker
//  Description : Combinational round-robin picker. Returns the first asserted
//                request found when searching ptr, ptr+1, ... modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Ports
//    req_valid    in   NUM_REQ  per-requester request
//    ptr          in   ID_W     highest-priority index for this search
//    grant_onehot out  NUM_REQ  one-hot grant, all zero when nothing requests
//    grant_idx    out  ID_W     binary index of the grant (0 when none)
//    any_valid    out  1        at least one request is asserted
// ============================================================================
module relu_arbiter_rr_picker
  import relu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] cand_idx;

  // Walk the search order from the farthest offset back to offset 0, so the
  // last hit written is the one closest to ptr.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_valid    = 1'b0;
    cand_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand_idx]) begin
        grant_onehot           = '0;
        grant_onehot[cand_idx] = 1'b1;
        grant_idx              = cand_idx;
        any_valid              = 1'b1;
      end
    end
  end

endmodule : relu_arbiter_rr_picker
`default_nettype wire

// File: rtl/relu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : relu_arbiter
//  Description : Shares one registered RELU unit among NUM_REQ requesters.
//                Round-robin grant in IDLE, operand held for the RELU latency
//                in WAIT, tagged result offered on a valid/ready port in
//                RESULT.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Ports
//    Clock            in   1            rising-edge clock
//    ResetN           in   1            asynchronous active-low reset
//    ReqValid         in   NUM_REQ      per-requester operand valid
//    ReqReady         out  NUM_REQ      one-hot accept (IDLE only)
//    ReqData          in   NUM_REQ*19   slice i = {sign, exp[5:0], mant[11:0]}
//    ReluSign         out  1            operand sign to RELU
//    ReluExponent     out  6            operand exponent to RELU
//    ReluMantissa     out  12           operand mantissa to RELU
//    ReluSignOut      in   1            RELU result sign
//    ReluExponentOut  in   5            RELU result exponent
//    ReluMantissaOut  in   6            RELU result mantissa
//    OutValid         out  1            result valid
//    OutReady         in   1            consumer accepts result
//    OutId            out  ID_W         requester index of the result
//    OutSign          out  1            result sign
//    OutExponent      out  5            result exponent
//    OutMantissa      out  6            result mantissa
//    Busy             out  1            FSM is not in IDLE
// ============================================================================
module relu_arbiter
  import relu_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int RELU_LATENCY = 1
) (
  input  logic                          Clock,
  input  logic                          ResetN,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [NUM_REQ*FLT_IN_W-1:0]   ReqData,
  output logic                          ReluSign,
  output logic [EXP_IN_W-1:0]           ReluExponent,
  output logic [MAN_IN_W-1:0]           ReluMantissa,
  input  logic                          ReluSignOut,
  input  logic [EXP_OUT_W-1:0]          ReluExponentOut,
  input  logic [MAN_OUT_W-1:0]          ReluMantissaOut,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [ID_W-1:0]               OutId,
  output logic                          OutSign,
  output logic [EXP_OUT_W-1:0]          OutExponent,
  output logic [MAN_OUT_W-1:0]          OutMantissa,
  output logic                          Busy
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t          state_q,     state_d;
  logic [ID_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  operand_t        operand_q,   operand_d;
  result_t         result_q,    result_d;
  logic [ID_W-1:0] out_id_q,    out_id_d;
  logic            out_valid_q, out_valid_d;

  // Picker outputs
  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               any_valid;

  relu_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid    (ReqValid),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_valid    (any_valid)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      operand_q   <= '0;
      result_q    <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      operand_q   <= operand_d;
      result_q    <= result_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath load logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    operand_d   = operand_q;
    result_d    = result_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        // ReqReady is the picker's one-hot grant, so any asserted request
        // means the granted requester completes its handshake this cycle.
        if (any_valid) begin
          operand_d = operand_t'(ReqData[int'(grant_idx)*FLT_IN_W +: FLT_IN_W]);
          out_id_d  = grant_idx;
          ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d     = CNT_W'(RELU_LATENCY);
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        // Counting down from RELU_LATENCY to 0 gives LATENCY+1 WAIT cycles;
        // the RELU output is sampled on the cycle the count reaches zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d    = '{sign:     ReluSignOut,
                          exponent: ReluExponentOut,
                          mantissa: ReluMantissaOut};
          out_valid_d = 1'b1;
          state_d     = S_RESULT;
        end
      end

      S_RESULT: begin
        // Return to IDLE only; the next grant is made from IDLE, never in the
        // same cycle as the result handshake.
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    ReqReady = '0;
    Busy     = (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      ReqReady = grant_onehot;
    end
  end

  // RELU sees the held operand continuously so any pipeline depth up to the
  // configured latency observes a stable input.
  assign ReluSign     = operand_q.sign;
  assign ReluExponent = operand_q.exponent;
  assign ReluMantissa = operand_q.mantissa;

  assign OutValid    = out_valid_q;
  assign OutId       = out_id_q;
  assign OutSign     = result_q.sign;
  assign OutExponent = result_q.exponent;
  assign OutMantissa = result_q.mantissa;

endmodule : relu_arbiter
`default_nettype wire

// File: tb/tb_relu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relu_arbiter
//  Description : Self-checking bench for relu_arbiter. A main instance with
//                RELU_LATENCY=1 plus two small instances with latency 0 and 3.
//                Expected values come from a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_arbiter;

  localparam int N = 4;
  localparam int W = 19;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // ---------------- main instance (latency 1) ----------------
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           relu_sign;
  logic [5:0]     relu_exp;
  logic [11:0]    relu_man;
  logic [11:0]    stub_q;
  logic           out_valid, out_ready, out_sign, busy;
  logic [1:0]     out_id;
  logic [4:0]     out_exp;
  logic [5:0]     out_man;

  // RELU stub: positive -> {0, exp[4:0], mant[11:6]}, negative -> 0.
  function automatic logic [11:0] stub_f(logic s, logic [5:0] e, logic [11:0] m);
    return s ? 12'd0 : {1'b0, e[4:0], m[11:6]};
  endfunction

  always_ff @(posedge clk) stub_q <= stub_f(relu_sign, relu_exp, relu_man);

  relu_arbiter #(.NUM_REQ(N), .ID_W(2), .RELU_LATENCY(1)) u_dut (
    .Clock(clk), .ResetN(rst_n),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqData(req_data),
    .ReluSign(relu_sign), .ReluExponent(relu_exp), .ReluMantissa(relu_man),
    .ReluSignOut(stub_q[11]), .ReluExponentOut(stub_q[10:6]), .ReluMantissaOut(stub_q[5:0]),
    .OutValid(out_valid), .OutReady(out_ready), .OutId(out_id),
    .OutSign(out_sign), .OutExponent(out_exp), .OutMantissa(out_man), .Busy(busy)
  );

  // ---------------- latency-0 and latency-3 instances ----------------
  logic [N-1:0]   a_valid;
  logic [N*W-1:0] a_data;
  logic           a_ready;

  logic [N-1:0] a0_rdy, a3_rdy;
  logic         a0_rs, a3_rs, a0_ov, a3_ov, a0_os, a3_os, a0_busy, a3_busy;
  logic [5:0]   a0_re, a3_re, a0_om, a3_om;
  logic [11:0]  a0_rm, a3_rm, a0_stub, a3_p1, a3_p2, a3_p3;
  logic [1:0]   a0_id, a3_id;
  logic [4:0]   a0_oe, a3_oe;

  assign a0_stub = stub_f(a0_rs, a0_re, a0_rm);
  always_ff @(posedge clk) begin
    a3_p1 <= stub_f(a3_rs, a3_re, a3_rm);
    a3_p2 <= a3_p1;
    a3_p3 <= a3_p2;
  end

  relu_arbiter #(.NUM_REQ(N), .ID_W(2), .RELU_LATENCY(0)) u_dut_l0 (
    .Clock(clk), .ResetN(rst_n),
    .ReqValid(a_valid), .ReqReady(a0_rdy), .ReqData(a_data),
    .ReluSign(a0_rs), .ReluExponent(a0_re), .ReluMantissa(a0_rm),
    .ReluSignOut(a0_stub[11]), .ReluExponentOut(a0_stub[10:6]), .ReluMantissaOut(a0_stub[5:0]),
    .OutValid(a0_ov), .OutReady(a_ready), .OutId(a0_id),
    .OutSign(a0_os), .OutExponent(a0_oe), .OutMantissa(a0_om), .Busy(a0_busy)
  );

  relu_arbiter #(.NUM_REQ(N), .ID_W(2), .RELU_LATENCY(3)) u_dut_l3 (
    .Clock(clk), .ResetN(rst_n),
    .ReqValid(a_valid), .ReqReady(a3_rdy), .ReqData(a_data),
    .ReluSign(a3_rs), .ReluExponent(a3_re), .ReluMantissa(a3_rm),
    .ReluSignOut(a3_p3[11]), .ReluExponentOut(a3_p3[10:6]), .ReluMantissaOut(a3_p3[5:0]),
    .OutValid(a3_ov), .OutReady(a_ready), .OutId(a3_id),
    .OutSign(a3_os), .OutExponent(a3_oe), .OutMantissa(a3_om), .Busy(a3_busy)
  );

  // ---------------- reference model ----------------
  // Expected RELU result by arithmetic on the operand fields.
  function automatic logic [11:0] relu_ref(logic [18:0] op);
    int e, m;
    if (op[18]) return 12'd0;
    e = int'(op[17:12]) % 32;
    m = int'(op[11:0]) / 64;
    return 12'(e * 64 + m);
  endfunction

  // First requester found searching from p upward with wrap; -1 when none.
  function automatic int pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    return (N*W)'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the main instance: present mask/data in IDLE,
  // follow the operand through WAIT, hold the result for `stall` cycles,
  // then complete the result handshake.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N*W-1:0] data,
                         input int stall, output logic [11:0] got_res, output int got_id);
    int          g, cyc;
    logic [18:0] op;
    logic [11:0] er;
    got_res = '0;
    got_id  = -1;
    @(negedge clk);
    req_valid = mask;
    req_data  = data;
    out_ready = 1'b0;
    #1;
    g = pick(mask, model_ptr);
    check("req_ready_idle", 32'(req_ready), 32'(onehot(g)));
    check("busy_idle", 32'(busy), 32'd0);
    if (g < 0) return;
    op = data[W*g +: W];
    er = relu_ref(op);
    @(posedge clk);
    model_ptr = (g + 1) % N;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = N'($urandom());
      #1;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("relu_operand", 32'({relu_sign, relu_exp, relu_man}), 32'(op));
    end while (!out_valid && cyc < 12);
    check("latency", cyc, 32'd3);
    check("out_id", 32'(out_id), g);
    check("out_result", 32'({out_sign, out_exp, out_man}), 32'(er));
    got_id  = int'(out_id);
    got_res = {out_sign, out_exp, out_man};
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      req_valid = N'($urandom());
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_id", 32'(out_id), g);
      check("hold_result", 32'({out_sign, out_exp, out_man}), 32'(er));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = '1;
    #1;
    check("no_grant_at_handshake", 32'(req_ready), 32'd0);
    check("valid_at_handshake", 32'(out_valid), 32'd1);
    @(negedge clk);
    // Sampled before re-driving: the cycle after the handshake is IDLE again.
    check("grant_after_handshake", 32'(req_ready), 32'(onehot(pick('1, model_ptr))));
    check("valid_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]    res, res0, res3;
    int             id, t0, t3;
    logic [N*W-1:0] d;
    logic [18:0]    op;
    int             fair_exp [5];

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    a_valid   = '0;
    a_data    = '0;
    a_ready   = 1'b0;
    #1;
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_relu", 32'({relu_sign, relu_exp, relu_man}), 32'd0);
    check("rst_out", 32'({out_id, out_sign, out_exp, out_man}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all four requesting, grants rotate 0,1,2,3,0
    fair_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      run_txn('1, rand_data(), 0, res, id);
      check("fair_order", id, fair_exp[i]);
    end

    // Single positive operand on requester 0
    d = rand_data();
    d[18:0] = 19'b0_001110_000111111010;
    run_txn(4'b0001, d, 0, res, id);
    check("single_id", id, 0);
    check("single_res", 32'(res), 32'(12'b0_01110_000111));

    // Negative operand on requester 2 clamps to zero
    d = rand_data();
    d[2*W +: W] = {1'b1, 6'b100001, 12'hFFF};
    run_txn(4'b0100, d, 0, res, id);
    check("neg_id", id, 2);
    check("neg_res", 32'(res), 32'd0);

    // Backpressure: result held for 5 cycles
    run_txn(4'b1010, rand_data(), 5, res, id);

    // Randomised traffic
    for (int i = 0; i < 24; i++) begin
      run_txn(N'($urandom()), rand_data(), $urandom_range(0, 3), res, id);
    end

    // Reset while in WAIT
    @(negedge clk);
    req_valid = '1;
    req_data  = rand_data();
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_relu", 32'({relu_sign, relu_exp, relu_man}), 32'd0);
    check("midrst_out", 32'({out_id, out_sign, out_exp, out_man}), 32'd0);
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_txn('1, rand_data(), 1, res, id);
    check("midrst_next_grant", id, 0);

    // Latency 0 and 3 builds, single request on requester 0
    @(negedge clk);
    a_data  = rand_data();
    a_valid = 4'b0001;
    a_ready = 1'b1;
    op      = a_data[W-1:0];
    #1;
    check("l0_ready", 32'(a0_rdy), 32'd1);
    check("l3_ready", 32'(a3_rdy), 32'd1);
    @(posedge clk);
    t0 = -1;
    t3 = -1;
    res0 = '0;
    res3 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      a_valid = '0;
      if (k == 1) begin
        check("l0_busy", 32'(a0_busy), 32'd1);
        check("l3_busy", 32'(a3_busy), 32'd1);
      end
      if (a0_ov && t0 < 0) begin
        t0 = k;
        res0 = {a0_os, a0_oe, a0_om};
        check("l0_id", 32'(a0_id), 32'd0);
      end
      if (a3_ov && t3 < 0) begin
        t3 = k;
        res3 = {a3_os, a3_oe, a3_om};
        check("l3_id", 32'(a3_id), 32'd0);
      end
    end
    check("l0_latency", t0, 32'd2);
    check("l3_latency", t3, 32'd5);
    check("l0_result", 32'(res0), 32'(relu_ref(op)));
    check("l3_result", 32'(res3), 32'(relu_ref(op)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_relu_arbiter
`default_nettype wire
